// File: rtl/simd_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : simd_alu_pipe_if
// Brief  : Operand/result handshake bundle for simd_alu_pipe.
// Rev    : 1.0 - initial release
// ============================================================================
interface simd_alu_pipe_if #(
  parameter int LANES  = 8,
  parameter int LANE_W = 32
);
  localparam int VW = LANES * LANE_W;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [VW-1:0]    src_a;
  logic [VW-1:0]    src_b;
  logic [LANES-1:0] lane_mask;
  logic [2:0]       wa3_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [VW-1:0]    result;
  logic [2:0]       wa3_out;
  logic             zero;

  modport master (
    output in_valid, op, src_a, src_b, lane_mask, wa3_in, flush, out_ready,
    input  in_ready, out_valid, result, wa3_out, zero
  );

  modport slave (
    input  in_valid, op, src_a, src_b, lane_mask, wa3_in, flush, out_ready,
    output in_ready, out_valid, result, wa3_out, zero
  );
endinterface
`default_nettype wire

// File: rtl/simd_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module : simd_alu_pipe
// Brief  : Two-stage masked SIMD ALU with valid/ready flow control and flush.
//          Define SIMD_ALU_SAT_EN for unsigned-saturating ADD/SUB.
// Rev    : 1.0 - initial release
// ============================================================================
module simd_alu_pipe #(
  parameter int LANES  = 8,
  parameter int LANE_W = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  simd_alu_pipe_if.slave   s_bus
);
  localparam int VW   = LANES * LANE_W;
  localparam int SH_W = $clog2(LANE_W);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SHL = 3'b101;
  localparam logic [2:0] c_OP_SHR = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [VW-1:0]    r_s1_a;
  logic [VW-1:0]    r_s1_b;
  logic [LANES-1:0] r_s1_mask;
  logic [2:0]       r_s1_tag;

  logic             r_s2_valid;
  logic [VW-1:0]    r_result;
  logic [2:0]       r_tag;
  logic             r_zero;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_accept;
  logic [VW-1:0]    w_merged;

  function automatic logic [LANE_W-1:0] f_lane(
    input logic [2:0]        op_f,
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b
  );
    logic [LANE_W-1:0] v_res;
`ifdef SIMD_ALU_SAT_EN
    logic [LANE_W:0]   v_sum;
    v_sum = {1'b0, a} + {1'b0, b};
`endif
    v_res = '0;
    case (op_f)
`ifdef SIMD_ALU_SAT_EN
      c_OP_ADD: v_res = v_sum[LANE_W] ? '1 : v_sum[LANE_W-1:0];
      c_OP_SUB: v_res = (a < b) ? '0 : (a - b);
`else
      c_OP_ADD: v_res = a + b;
      c_OP_SUB: v_res = a - b;
`endif
      c_OP_AND: v_res = a & b;
      c_OP_OR:  v_res = a | b;
      c_OP_XOR: v_res = a ^ b;
      // only the low log2(LANE_W) bits of the lane form the shift amount
      c_OP_SHL: v_res = a << b[SH_W-1:0];
      c_OP_SHR: v_res = a >> b[SH_W-1:0];
      c_OP_MUL: v_res = a * b;
      default:  v_res = '0;
    endcase
    return v_res;
  endfunction

  assign w_s2_load = !r_s2_valid || s_bus.out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_accept  = w_s1_load && !s_bus.flush;

  // Masked-off lanes forward src_a untouched
  always_comb begin
    w_merged = r_s1_a;
    for (int i = 0; i < LANES; i++) begin
      if (r_s1_mask[i]) begin
        w_merged[i*LANE_W +: LANE_W] = f_lane(r_s1_op,
                                              r_s1_a[i*LANE_W +: LANE_W],
                                              r_s1_b[i*LANE_W +: LANE_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mask  <= '0;
      r_s1_tag   <= '0;
    end else if (s_bus.flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= s_bus.in_valid;
      if (s_bus.in_valid) begin
        r_s1_op   <= s_bus.op;
        r_s1_a    <= s_bus.src_a;
        r_s1_b    <= s_bus.src_b;
        r_s1_mask <= s_bus.lane_mask;
        r_s1_tag  <= s_bus.wa3_in;
      end
    end
  end

  // Result registers only change when a real bundle lands in S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_tag      <= '0;
      r_zero     <= 1'b1;
    end else if (s_bus.flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_merged;
        r_tag    <= r_s1_tag;
        r_zero   <= (w_merged == '0);
      end
    end
  end

  assign s_bus.in_ready  = w_accept;
  assign s_bus.out_valid = r_s2_valid;
  assign s_bus.result    = r_result;
  assign s_bus.wa3_out   = r_tag;
  assign s_bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_simd_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_simd_alu_pipe
// Brief  : Self-checking bench: directed vector table, handshake sequences and
//          randomized traffic against a transaction-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_simd_alu_pipe;
  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int VW     = LANES * LANE_W;

  typedef struct {
    logic [2:0]    op;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [7:0]    mask;
    logic [VW-1:0] exp;
    logic          exp_zero;
  } vec_t;

  typedef struct {
    logic [VW-1:0] res;
    logic [2:0]    tag;
    logic          zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simd_alu_pipe_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();
  simd_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  exp_t          sb_q[$];
  logic          s_ready, s_ovalid, s_acc, s_out, s_zero;
  logic [VW-1:0] s_res;
  logic [2:0]    s_tag;
  logic          p_hold = 1'b0;
  logic [VW-1:0] p_res;
  logic [2:0]    p_tag;
  vec_t          tbl[11];

  task automatic chk_v(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Reference lane op computed in 64-bit unsigned arithmetic
  function automatic logic [31:0] model_lane(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned la, lb, r;
    la = 64'(a);
    lb = 64'(b);
    r  = 0;
    case (op)
`ifdef SIMD_ALU_SAT_EN
      3'd0: begin r = la + lb; if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF; end
      3'd1: r = (la < lb) ? 64'd0 : la - lb;
`else
      3'd0: r = la + lb;
      3'd1: r = la + 64'h1_0000_0000 - lb;
`endif
      3'd2: r = la & lb;
      3'd3: r = la | lb;
      3'd4: r = la ^ lb;
      3'd5: r = la << (lb % 64'd32);
      3'd6: r = la >> (lb % 64'd32);
      default: r = la * lb;
    endcase
    r = r % 64'h1_0000_0000;
    return r[31:0];
  endfunction

  function automatic exp_t model_vec(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                     input logic [7:0] mask, input logic [2:0] tag);
    exp_t e;
    e.res  = '0;
    e.tag  = tag;
    e.zero = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      e.res[l*32 +: 32] = mask[l] ? model_lane(op, a[l*32 +: 32], b[l*32 +: 32]) : a[l*32 +: 32];
      if (e.res[l*32 +: 32] != 32'd0) e.zero = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom % 4)
      0: return 32'($urandom);
      1: return 32'd0;
      2: return 32'hFFFF_FFFF;
      default: return 32'($urandom % 64);
    endcase
  endfunction

  task automatic set_idle();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.op        = 3'd0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.lane_mask = '0;
    bus.wa3_in    = 3'd0;
  endtask

  task automatic drive_rand(input logic [2:0] tag);
    logic [31:0] a_l;
    bus.in_valid  = 1'b1;
    bus.op        = 3'($urandom);
    bus.lane_mask = 8'($urandom);
    bus.wa3_in    = tag;
    for (int l = 0; l < LANES; l++) begin
      a_l = rnd_word();
      bus.src_a[l*32 +: 32] = a_l;
      bus.src_b[l*32 +: 32] = (($urandom % 5) == 0) ? a_l : rnd_word();
    end
  endtask

  // Sample between edges, run the scoreboard, then advance one clock
  task automatic tick();
    exp_t e;
    #1;
    s_ready  = bus.in_ready;
    s_ovalid = bus.out_valid;
    s_res    = bus.result;
    s_tag    = bus.wa3_out;
    s_zero   = bus.zero;
    s_acc    = bus.in_valid && bus.in_ready;
    s_out    = bus.out_valid && bus.out_ready;
    if (bus.flush) begin
      sb_q.delete();
    end else begin
      if (s_out) begin
        if (sb_q.size() == 0) begin
          chk_i("sb_unexpected_output_tag", int'(s_tag), -1);
        end else begin
          e = sb_q.pop_front();
          chk_v("sb_result", s_res, e.res);
          chk_i("sb_tag", int'(s_tag), int'(e.tag));
          chk_i("sb_zero", int'(s_zero), int'(e.zero));
        end
      end
      if (s_acc) sb_q.push_back(model_vec(bus.op, bus.src_a, bus.src_b, bus.lane_mask, bus.wa3_in));
    end
    if (p_hold) begin
      chk_i("hold_valid", int'(s_ovalid), 1);
      chk_v("hold_result", s_res, p_res);
      chk_i("hold_tag", int'(s_tag), int'(p_tag));
    end
    p_hold = s_ovalid && !bus.out_ready && !bus.flush;
    p_res  = s_res;
    p_tag  = s_tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (s_ovalid) return;
      lat++;
    end
    lat = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, acc, nout;
    int got[$];

    tbl[0]  = '{3'd0, {8{32'h5}}, {8{32'h3}}, 8'hFF, {8{32'h8}}, 1'b0};
`ifdef SIMD_ALU_SAT_EN
    tbl[1]  = '{3'd0, {224'h0, 32'hFFFF_FFFF}, {224'h0, 32'h2}, 8'hFF, {224'h0, 32'hFFFF_FFFF}, 1'b0};
    tbl[10] = '{3'd1, {VW{1'b0}}, {8{32'h1}}, 8'hFF, {VW{1'b0}}, 1'b1};
`else
    tbl[1]  = '{3'd0, {224'h0, 32'hFFFF_FFFF}, {224'h0, 32'h2}, 8'hFF, {224'h0, 32'h1}, 1'b0};
    tbl[10] = '{3'd1, {VW{1'b0}}, {8{32'h1}}, 8'hFF, {8{32'hFFFF_FFFF}}, 1'b0};
`endif
    tbl[2]  = '{3'd1, {128'h0, {4{32'h1234}}}, {8{32'h1234}}, 8'h0F, {VW{1'b0}}, 1'b1};
    tbl[3]  = '{3'd1, {{4{32'hA}}, {4{32'h1234}}}, {8{32'h1234}}, 8'h0F, {{4{32'hA}}, 128'h0}, 1'b0};
    tbl[4]  = '{3'd5, {8{32'h1}}, {8{32'h21}}, 8'hFF, {8{32'h2}}, 1'b0};
    tbl[5]  = '{3'd7, {8{32'h0001_0000}}, {8{32'h0001_0000}}, 8'hFF, {VW{1'b0}}, 1'b1};
    tbl[6]  = '{3'd2, {8{32'hF0F0_F0F0}}, {8{32'hFF00_FF00}}, 8'hFF, {8{32'hF000_F000}}, 1'b0};
    tbl[7]  = '{3'd3, {8{32'hF0F0_F0F0}}, {8{32'hFF00_FF00}}, 8'hFF, {8{32'hFFF0_FFF0}}, 1'b0};
    tbl[8]  = '{3'd4, {8{32'hF0F0_F0F0}}, {8{32'hFF00_FF00}}, 8'hFF, {8{32'h0FF0_0FF0}}, 1'b0};
    tbl[9]  = '{3'd6, {8{32'h8000_0000}}, {8{32'h3F}}, 8'hFF, {8{32'h1}}, 1'b0};

    set_idle();
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_i("rst_in_ready", int'(bus.in_ready), 1);
    chk_i("rst_out_valid", int'(bus.out_valid), 0);
    chk_v("rst_result", bus.result, '0);
    chk_i("rst_wa3_out", int'(bus.wa3_out), 0);
    chk_i("rst_zero", int'(bus.zero), 1);
    @(negedge clk);

    // Directed vectors, one bundle at a time
    for (int i = 0; i < 11; i++) begin
      bus.in_valid  = 1'b1;
      bus.op        = tbl[i].op;
      bus.src_a     = tbl[i].a;
      bus.src_b     = tbl[i].b;
      bus.lane_mask = tbl[i].mask;
      bus.wa3_in    = 3'((i % 7) + 1);
      bus.out_ready = 1'b1;
      tick();
      chk_i("tbl_accept", int'(s_acc), 1);
      set_idle();
      wait_out(lat);
      chk_i("tbl_latency", lat, 2);
      chk_v("tbl_result", s_res, tbl[i].exp);
      chk_i("tbl_zero", int'(s_zero), int'(tbl[i].exp_zero));
      chk_i("tbl_tag", int'(s_tag), (i % 7) + 1);
    end

    // Backpressure: only two bundles fit, then ordered drain
    bus.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive_rand(3'(acc + 1));
      tick();
      if (s_acc) acc++;
    end
    chk_i("bp_accepted", acc, 2);
    chk_i("bp_in_ready", int'(s_ready), 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 30 && got.size() < 4; k++) begin
      if (acc < 4) drive_rand(3'(acc + 1));
      else set_idle();
      tick();
      if (s_acc) acc++;
      if (s_out) got.push_back(int'(s_tag));
    end
    chk_i("bp_out_count", got.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < got.size()) chk_i("bp_order", got[j], j + 1);
    end
    set_idle();
    tick();

    // Flush with two bundles in flight
    bus.out_ready = 1'b0;
    drive_rand(3'd5);
    tick();
    drive_rand(3'd6);
    tick();
    drive_rand(3'd7);
    bus.flush = 1'b1;
    tick();
    chk_i("fl_in_ready", int'(s_ready), 0);
    chk_i("fl_not_accepted", int'(s_acc), 0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk_i("fl_out_valid_after", int'(s_ovalid), 0);
    chk_i("fl_next_accept", int'(s_acc), 1);
    set_idle();
    wait_out(lat);
    chk_i("fl_next_latency", lat, 2);
    chk_i("fl_next_tag", int'(s_tag), 7);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      drive_rand(3'($urandom));
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      tick();
    end
    set_idle();
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk_i("sb_drained", sb_q.size(), 0);

    // Reset in the middle of traffic
    bus.out_ready = 1'b0;
    drive_rand(3'd3);
    tick();
    drive_rand(3'd4);
    tick();
    set_idle();
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    p_hold = 1'b0;
    #1;
    chk_i("arst_out_valid", int'(bus.out_valid), 0);
    chk_i("arst_in_ready", int'(bus.in_ready), 1);
    chk_v("arst_result", bus.result, '0);
    chk_i("arst_zero", int'(bus.zero), 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    nout = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (s_ovalid) nout++;
    end
    chk_i("arst_no_output", nout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
